// File: rtl/pattern_pkg.sv
// Shared definitions for the serial codeword detector: state encoding, reset
// defaults and a saturating increment used by the counters.
package pattern_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_FILL    = 2'd1;
  localparam state_t S_HUNT    = 2'd2;
  localparam state_t S_HOLDOFF = 2'd3;

  localparam logic [15:0] PKG_DEFAULT_PATTERN = 16'h07D5;
  localparam int unsigned PKG_DEFAULT_LEN     = 11;

  // Callers cast in and out of 32 bits so one function serves every width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/win_counter.sv
// Per-window event counter: saturating running count, closed-window capture
// with a valid pulse, and a saturation flag cleared at each window close.
module win_counter
  import pattern_pkg::*;
#(
  parameter int unsigned CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             max_tick,
  output logic [CNT_W-1:0] window_count,
  output logic             window_valid,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  logic [CNT_W-1:0] run_q, run_d, run_inc;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             wvalid_d, wvalid_q;
  logic             sat_q, sat_d;

  always_comb begin
    run_inc  = CNT_W'(sat_inc(32'(run_q), 32'(MAX_CNT)));
    run_d    = run_q;
    sat_d    = sat_q;
    wcnt_d   = wcnt_q;
    wvalid_d = 1'b0;
    if (max_tick) begin
      // An event on the closing cycle belongs to the window being closed.
      wcnt_d   = inc ? run_inc : run_q;
      wvalid_d = 1'b1;
      run_d    = '0;
      sat_d    = 1'b0;
    end else if (inc) begin
      run_d = run_inc;
      sat_d = sat_q | (run_inc == MAX_CNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= '0;
      sat_q    <= 1'b0;
      wcnt_q   <= '0;
      wvalid_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      sat_q    <= sat_d;
      wcnt_q   <= wcnt_d;
      wvalid_q <= wvalid_d;
    end
  end

  assign window_count = wcnt_q;
  assign window_valid = wvalid_q;
  assign cnt_sat      = sat_q;

endmodule

// File: rtl/pattern_detector.sv
// Serial codeword detector with runtime-loadable pattern, overlapping or
// non-overlapping matching, and per-window detection counting.
module pattern_detector
  import pattern_pkg::*;
#(
  parameter int unsigned         MAX_LEN         = 16,
  parameter logic [MAX_LEN-1:0]  DEFAULT_PATTERN = MAX_LEN'(PKG_DEFAULT_PATTERN),
  parameter int unsigned         DEFAULT_LEN     = PKG_DEFAULT_LEN,
  parameter int unsigned         CNT_W           = 11,
  parameter int unsigned         LEN_W           = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               max_tick,
  output logic               cw_detected,
  output logic [CNT_W-1:0]   window_count,
  output logic               window_valid,
  output logic               cnt_sat,
  output logic               cfg_err
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] sreg_q, sreg_d, sreg_shift;
  logic [MAX_LEN-1:0] pat_q, pat_d, mask;
  logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, fill_inc;
  logic               ovl_q, ovl_d;
  logic               det_q, err_q, err_d;
  logic               cfg_ok, accept, match;
  logic               unused_sreg_msb;

  assign unused_sreg_msb = sreg_q[MAX_LEN-1];

  always_comb begin
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  always_comb begin
    cfg_ok     = cfg_load && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    accept     = en && bit_valid && (state_q != S_IDLE) && !cfg_ok;
    sreg_shift = {sreg_q[MAX_LEN-2:0], bit_in};
    fill_inc   = LEN_W'(sat_inc(32'(fill_q), MAX_LEN));
    match      = accept && (fill_inc >= len_q) && (((sreg_shift ^ pat_q) & mask) == '0);

    state_d = state_q;
    sreg_d  = sreg_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    err_d   = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      fill_d  = '0;
    end else if (state_q == S_IDLE) begin
      state_d = S_FILL;
      fill_d  = '0;
    end else if (accept) begin
      sreg_d = sreg_shift;
      fill_d = fill_inc;
      if (match) begin
        if (ovl_q) begin
          state_d = S_HUNT;
        end else begin
          // Non-overlapping: the next match must be built from fresh bits.
          state_d = S_HOLDOFF;
          fill_d  = '0;
        end
      end
    end

    if (cfg_load) begin
      if (cfg_ok) begin
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        sreg_d  = '0;
        fill_d  = '0;
        state_d = en ? S_FILL : S_IDLE;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEFAULT_PATTERN;
      len_q   <= LEN_W'(DEFAULT_LEN);
      ovl_q   <= 1'b1;
      det_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      det_q   <= match;
      err_q   <= err_d;
    end
  end

  assign cw_detected = det_q;
  assign cfg_err     = err_q;

  win_counter #(
    .CNT_W(CNT_W)
  ) u_win_counter (
    .clk          (clk),
    .rst          (rst),
    .inc          (match),
    .max_tick     (max_tick),
    .window_count (window_count),
    .window_valid (window_valid),
    .cnt_sat      (cnt_sat)
  );

endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector: two instances (default counter width and a 3-bit
// counter) driven together and compared every cycle against a history-queue model.
module tb_pattern_detector;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, en, bit_in, bit_valid, cfg_load, cfg_overlap, max_tick;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;

  logic        cw_a, wv_a, sat_a, err_a;
  logic [10:0] wc_a;
  logic        cw_b, wv_b, sat_b, err_b;
  logic [2:0]  wc_b;

  pattern_detector u_dut_a (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .bit_valid(bit_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .max_tick(max_tick), .cw_detected(cw_a),
    .window_count(wc_a), .window_valid(wv_a), .cnt_sat(sat_a), .cfg_err(err_a)
  );

  pattern_detector #(.CNT_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .bit_valid(bit_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .max_tick(max_tick), .cw_detected(cw_b),
    .window_count(wc_b), .window_valid(wv_b), .cnt_sat(sat_b), .cfg_err(err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fresh accepted bits since the last clear, plus counters.
  bit          m_active;
  bit          hist[$];
  logic [15:0] m_pat;
  int          m_len;
  bit          m_ovl, m_cw, m_err;
  int          m_run[2], m_wc[2];
  bit          m_wv[2], m_sat[2];
  int          max_cnt[2] = '{2047, 7};

  task automatic model_reset();
    m_active = 0;
    hist.delete();
    m_pat = 16'h07D5;
    m_len = 11;
    m_ovl = 1;
    m_cw  = 0;
    m_err = 0;
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_wc[i] = 0; m_wv[i] = 0; m_sat[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit ok, acc, match;
    int n;
    ok    = cfg_load && (int'(cfg_len) >= 1) && (int'(cfg_len) <= MAX_LEN);
    acc   = en && bit_valid && m_active && !ok;
    match = 0;
    if (acc) begin
      hist.push_back(bit_in);
      if (hist.size() > MAX_LEN) void'(hist.pop_front());
      n = hist.size();
      if (n >= m_len) begin
        match = 1;
        for (int k = 0; k < m_len; k++) if (hist[n-1-k] != m_pat[k]) match = 0;
      end
      if (match && !m_ovl) hist.delete();
    end
    if (!en || !m_active) hist.delete();
    if (ok) begin
      m_pat = cfg_pattern;
      m_len = int'(cfg_len);
      m_ovl = cfg_overlap;
      hist.delete();
    end
    m_active = en;
    m_cw  = match;
    m_err = cfg_load && !ok;
    for (int i = 0; i < 2; i++) begin
      m_wv[i] = max_tick;
      if (max_tick) begin
        m_wc[i]  = (m_run[i] + int'(match) > max_cnt[i]) ? max_cnt[i] : m_run[i] + int'(match);
        m_run[i] = 0;
        m_sat[i] = 0;
      end else if (match) begin
        if (m_run[i] < max_cnt[i]) m_run[i]++;
        if (m_run[i] == max_cnt[i]) m_sat[i] = 1;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("cw_a", 32'(cw_a), 32'(m_cw));
    check_eq("err_a", 32'(err_a), 32'(m_err));
    check_eq("wv_a", 32'(wv_a), 32'(m_wv[0]));
    check_eq("wc_a", 32'(wc_a), 32'(m_wc[0]));
    check_eq("sat_a", 32'(sat_a), 32'(m_sat[0]));
    check_eq("cw_b", 32'(cw_b), 32'(m_cw));
    check_eq("err_b", 32'(err_b), 32'(m_err));
    check_eq("wv_b", 32'(wv_b), 32'(m_wv[1]));
    check_eq("wc_b", 32'(wc_b), 32'(m_wc[1]));
    check_eq("sat_b", 32'(sat_b), 32'(m_sat[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (cw_a) pulses++;
    cfg_load = 0;
    max_tick = 0;
  endtask

  task automatic do_reset();
    #2 rst = 1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 0;
  endtask

  task automatic load(input logic [15:0] pat, input int len, input bit ovl);
    cfg_load = 1; cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
    bit_valid = 0;
    cycle();
  endtask

  task automatic send_bits(input logic [15:0] v, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      bit_in = v[i]; bit_valid = 1;
      cycle();
      if (gaps) begin
        bit_in = ~v[i]; bit_valid = 0;
        cycle();
      end
    end
    bit_valid = 0;
  endtask

  task automatic idle(input int n);
    bit_valid = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 0; en = 0; bit_in = 0; bit_valid = 0; cfg_load = 0; cfg_pattern = '0;
    cfg_len = '0; cfg_overlap = 0; max_tick = 0;
    do_reset();
    check_eq("reset_cw", 32'(cw_a), 32'd0);
    check_eq("reset_wc", 32'(wc_a), 32'd0);

    // Default codeword, contiguous.
    en = 1; idle(1);
    pulses = 0;
    send_bits(16'h07D5, 11, 0);
    idle(1);
    check_eq("pulses_default", 32'(pulses), 32'd1);
    max_tick = 1; cycle();
    check_eq("win_default", 32'(wc_a), 32'd1);
    check_eq("wvalid_default", 32'(wv_a), 32'd1);
    idle(1);
    check_eq("wvalid_drop", 32'(wv_a), 32'd0);

    // 101 overlapping, then non-overlapping.
    load(16'h0005, 3, 1);
    pulses = 0; send_bits(16'h0015, 5, 0); idle(1);
    check_eq("pulses_ovl", 32'(pulses), 32'd2);
    load(16'h0005, 3, 0);
    pulses = 0; send_bits(16'h0015, 5, 0); idle(1);
    check_eq("pulses_novl", 32'(pulses), 32'd1);

    // Default codeword with bit_valid gaps.
    load(16'h07D5, 11, 1);
    pulses = 0; send_bits(16'h07D5, 11, 1); idle(1);
    check_eq("pulses_gaps", 32'(pulses), 32'd1);

    // len 1, ten ones: the 3-bit counter saturates at 7.
    load(16'h0001, 1, 1);
    max_tick = 1; cycle();
    send_bits(16'h03FF, 10, 0);
    check_eq("sat_b_set", 32'(sat_b), 32'd1);
    max_tick = 1; cycle();
    check_eq("sat_win_b", 32'(wc_b), 32'd7);
    check_eq("sat_win_a", 32'(wc_a), 32'd10);
    check_eq("sat_b_clr", 32'(sat_b), 32'd0);

    // Match on the max_tick cycle lands in the closing window.
    bit_in = 1; bit_valid = 1; cycle();
    bit_in = 1; bit_valid = 1; max_tick = 1; cycle();
    check_eq("tick_match_win", 32'(wc_a), 32'd2);
    bit_valid = 0; max_tick = 1; cycle();
    check_eq("tick_next_win", 32'(wc_a), 32'd0);

    // Rejected loads leave detection running.
    cfg_load = 1; cfg_len = 5'd0; bit_in = 1; bit_valid = 1; cycle();
    check_eq("err_len0", 32'(err_a), 32'd1);
    cfg_load = 1; cfg_len = 5'd17; bit_in = 1; bit_valid = 1; cycle();
    check_eq("err_len17", 32'(err_a), 32'd1);
    check_eq("err_still_det", 32'(cw_a), 32'd1);
    bit_valid = 0; cycle();

    // Reset mid-pattern, then the tail alone must not match.
    load(16'h07D5, 11, 1);
    send_bits(16'h003E, 6, 0);
    do_reset();
    pulses = 0;
    send_bits(16'h0015, 5, 0); idle(2);
    check_eq("reset_no_false", 32'(pulses), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      en        = ($urandom_range(0, 49) != 0);
      bit_in    = 1'($urandom);
      bit_valid = ($urandom_range(0, 3) != 0);
      max_tick  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) begin
        int r;
        r = $urandom_range(0, 9);
        cfg_load    = 1;
        cfg_pattern = 16'($urandom);
        cfg_overlap = 1'($urandom);
        if (r == 0)      cfg_len = 5'd0;
        else if (r == 1) cfg_len = 5'd17;
        else if (r == 2) cfg_len = 5'($urandom_range(1, 16));
        else             cfg_len = 5'($urandom_range(1, 4));
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
